lcd_bus_reader: RTL and testbench



---
 rtl/lcd_pkg.sv | 32 +++
 rtl/lcd_bus_timer.sv | 41 ++++
 rtl/lcd_bus_reader.sv | 240 ++++++++++++++++++++++++
 tb/tb_lcd_bus_reader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared definitions for the HD44780-style LCD bus (read and write paths).
//   - lcd_rd_state_t : read-side bus cycle states
//   - LCD_RS_CMD / LCD_RS_DATA : register-select encodings
//   - LCD_BF_BIT : position of the busy flag in a status read
//   - default bus timing constants, in 50 MHz clk cycles
//   - lcd_max2() : helper for sizing counters from timing parameters
package lcd_pkg;

  typedef enum logic [2:0] {
    LCD_RD_IDLE    = 3'd0,
    LCD_RD_SETUP   = 3'd1,
    LCD_RD_EN_HIGH = 3'd2,
    LCD_RD_HOLD    = 3'd3,
    LCD_RD_RECOVER = 3'd4
  } lcd_rd_state_t;

  localparam logic LCD_RS_CMD  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  localparam int unsigned LCD_BF_BIT = 32'd7;

  localparam int unsigned LCD_SETUP_CYCLES   = 32'd3;
  localparam int unsigned LCD_EN_HIGH_CYCLES = 32'd25;
  localparam int unsigned LCD_HOLD_CYCLES    = 32'd3;
  localparam int unsigned LCD_RECOVER_CYCLES = 32'd19;
  localparam int unsigned LCD_POLL_LIMIT     = 32'd255;

  function automatic int unsigned lcd_max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_bus_timer.sv
// lcd_bus_timer: loadable down-counter used to time LCD bus phases.
//   clk, reset (sync, active-high) ; load/load_val : restart the count
//   done : count has reached zero (decoded from the count register)
// The counter stops at zero until reloaded.
module lcd_bus_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: load has priority, otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// lcd_bus_reader: read-side master for the HD44780-style LCD bus (RW=1 cycles).
//   Request : req_valid/req_rs in, req_ready out (IDLE and bus_busy=0)
//   Bus     : lcd_en/lcd_rs/lcd_rw out, lcd_data_in in, bus_own out (top
//             level must tristate LCD_DATA while bus_own=1); never drives data
//   Response: resp_valid (1-cycle strobe), resp_data (held), resp_timeout
// Optional: define LCD_BUSY_POLL_EN to make RS=1 requests first poll the busy
// flag (RS=0 reads) until BF=0, giving up after POLL_LIMIT busy reads.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYCLES   = LCD_SETUP_CYCLES,
  parameter int unsigned EN_HIGH_CYCLES = LCD_EN_HIGH_CYCLES,
  parameter int unsigned HOLD_CYCLES    = LCD_HOLD_CYCLES,
  parameter int unsigned RECOVER_CYCLES = LCD_RECOVER_CYCLES,
  parameter int unsigned POLL_LIMIT     = LCD_POLL_LIMIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic       req_rs,
  output logic       req_ready,
  input  logic       bus_busy,
  output logic       bus_own,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       resp_valid,
  output logic [7:0] resp_data,
  output logic       resp_timeout
);

`ifdef LCD_BUSY_POLL_EN
  localparam bit POLL_EN = 1'b1;
`else
  localparam bit POLL_EN = 1'b0;
`endif

  localparam int unsigned MAX_P = lcd_max2(lcd_max2(lcd_max2(SETUP_CYCLES, EN_HIGH_CYCLES),
                                                    lcd_max2(HOLD_CYCLES, RECOVER_CYCLES)),
                                           POLL_LIMIT);
  localparam int unsigned CW = $clog2(MAX_P + 1);

  // Each phase lasts N cycles: the timer is loaded with N-1 on entry.
  localparam logic [CW-1:0] LD_SETUP   = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] LD_EN_HIGH = CW'(EN_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LD_HOLD    = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] LD_RECOVER = CW'(RECOVER_CYCLES - 1);
  localparam logic [7:0]    POLL_LIM8  = 8'(POLL_LIMIT);

  if (SETUP_CYCLES == 0 || EN_HIGH_CYCLES == 0 || HOLD_CYCLES == 0 ||
      RECOVER_CYCLES == 0 || POLL_LIMIT == 0 || POLL_LIMIT > 255) begin : g_bad_param
    $error("lcd_bus_reader: timing parameters must be nonzero and POLL_LIMIT <= 255");
  end

  lcd_rd_state_t state_d, state_q;
  logic       rs_d, rs_q, rw_d, rw_q, en_d, en_q, own_d, own_q;
  logic       rv_d, rv_q, tmo_d, tmo_q;
  logic [7:0] data_d, data_q;
  logic       poll_d, poll_q;   // current bus cycle is a busy-flag poll
  logic       pend_d, pend_q;   // next bus cycle is another poll
  logic       more_d, more_q;   // another bus cycle follows this one
  logic [7:0] pcnt_d, pcnt_q;
  logic [7:0] pcnt_inc;
  logic       tmr_load;
  logic [CW-1:0] tmr_val;
  logic       tmr_done;
  logic       accept;

  // req_ready gates on the live reset so it is low during reset and rises in
  // the very first cycle after release.
  assign req_ready = (state_q == LCD_RD_IDLE) && !bus_busy && !reset;
  assign accept    = req_valid && req_ready;
  assign pcnt_inc  = pcnt_q + 8'd1;

  lcd_bus_timer #(.WIDTH(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Bus-cycle sequencer: next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    rs_d     = rs_q;
    rw_d     = rw_q;
    en_d     = en_q;
    own_d    = own_q;
    rv_d     = 1'b0;
    tmo_d    = 1'b0;
    data_d   = data_q;
    poll_d   = poll_q;
    pend_d   = pend_q;
    more_d   = more_q;
    pcnt_d   = pcnt_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      LCD_RD_IDLE: begin
        if (accept) begin
          state_d  = LCD_RD_SETUP;
          tmr_load = 1'b1;
          tmr_val  = LD_SETUP;
          own_d    = 1'b1;
          rw_d     = 1'b1;
          en_d     = 1'b0;
          more_d   = 1'b0;
          pcnt_d   = 8'd0;
          if (POLL_EN && (req_rs == LCD_RS_DATA)) begin
            poll_d = 1'b1;
            rs_d   = LCD_RS_CMD;
          end else begin
            poll_d = 1'b0;
            rs_d   = req_rs;
          end
        end else begin
          state_d = LCD_RD_IDLE;
        end
      end
      LCD_RD_SETUP: begin
        if (tmr_done) begin
          state_d  = LCD_RD_EN_HIGH;
          tmr_load = 1'b1;
          tmr_val  = LD_EN_HIGH;
          en_d     = 1'b1;
        end else begin
          state_d = LCD_RD_SETUP;
        end
      end
      LCD_RD_EN_HIGH: begin
        if (tmr_done) begin
          state_d  = LCD_RD_HOLD;
          tmr_load = 1'b1;
          tmr_val  = LD_HOLD;
          en_d     = 1'b0;
          data_d   = lcd_data_in;
          if (poll_q) begin
            pcnt_d = pcnt_inc;
            if (!lcd_data_in[LCD_BF_BIT]) begin
              more_d = 1'b1;
              pend_d = 1'b0;
            end else if (pcnt_inc == POLL_LIM8) begin
              // Busy flag never cleared: report with the last status byte.
              rv_d   = 1'b1;
              tmo_d  = 1'b1;
              more_d = 1'b0;
            end else begin
              more_d = 1'b1;
              pend_d = 1'b1;
            end
          end else begin
            rv_d   = 1'b1;
            more_d = 1'b0;
          end
        end else begin
          state_d = LCD_RD_EN_HIGH;
        end
      end
      LCD_RD_HOLD: begin
        if (tmr_done) begin
          state_d  = LCD_RD_RECOVER;
          tmr_load = 1'b1;
          tmr_val  = LD_RECOVER;
          // Keep the bus between chained cycles so the writer cannot slip in.
          rw_d     = more_q;
          own_d    = more_q;
        end else begin
          state_d = LCD_RD_HOLD;
        end
      end
      LCD_RD_RECOVER: begin
        if (tmr_done) begin
          if (more_q) begin
            state_d  = LCD_RD_SETUP;
            tmr_load = 1'b1;
            tmr_val  = LD_SETUP;
            poll_d   = pend_q;
            rs_d     = pend_q ? LCD_RS_CMD : LCD_RS_DATA;
            rw_d     = 1'b1;
            own_d    = 1'b1;
            more_d   = 1'b0;
          end else begin
            state_d = LCD_RD_IDLE;
            poll_d  = 1'b0;
          end
        end else begin
          state_d = LCD_RD_RECOVER;
        end
      end
      default: begin
        state_d = LCD_RD_IDLE;
        en_d    = 1'b0;
        rw_d    = 1'b0;
        own_d   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LCD_RD_IDLE;
      rs_q    <= 1'b0;
      rw_q    <= 1'b0;
      en_q    <= 1'b0;
      own_q   <= 1'b0;
      rv_q    <= 1'b0;
      tmo_q   <= 1'b0;
      data_q  <= 8'd0;
      poll_q  <= 1'b0;
      pend_q  <= 1'b0;
      more_q  <= 1'b0;
      pcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      rw_q    <= rw_d;
      en_q    <= en_d;
      own_q   <= own_d;
      rv_q    <= rv_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      poll_q  <= poll_d;
      pend_q  <= pend_d;
      more_q  <= more_d;
      pcnt_q  <= pcnt_d;
    end
  end

  assign lcd_en       = en_q;
  assign lcd_rs       = rs_q;
  assign lcd_rw       = rw_q;
  assign bus_own      = own_q;
  assign resp_valid   = rv_q;
  assign resp_data    = data_q;
  assign resp_timeout = tmo_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// tb_lcd_bus_reader: randomized self-checking bench for lcd_bus_reader.
// The reference model describes a transaction by its cycle offset from the
// accept cycle: SETUP at 1..S, EN at S+1..S+E, response at S+E+1, bus released
// after S+E+H, ready again after S+E+H+R.
module tb_lcd_bus_reader;

  localparam int S = 3;
  localparam int E = 25;
  localparam int H = 3;
  localparam int R = 19;
  localparam int PLIM = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic       req_ready;
  logic       bus_busy = 1'b0;
  logic       bus_own;
  logic [7:0] lcd_data_in = 8'd0;
  logic       lcd_en, lcd_rs, lcd_rw;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic       resp_timeout;

  always #10 clk = ~clk;

  lcd_bus_reader #(
    .SETUP_CYCLES   (S),
    .EN_HIGH_CYCLES (E),
    .HOLD_CYCLES    (H),
    .RECOVER_CYCLES (R),
    .POLL_LIMIT     (PLIM)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_rs       (req_rs),
    .req_ready    (req_ready),
    .bus_busy     (bus_busy),
    .bus_own      (bus_own),
    .lcd_data_in  (lcd_data_in),
    .lcd_en       (lcd_en),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_timeout (resp_timeout)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  bit         model_on = 1'b0;
  bit         in_txn = 1'b0;
  bit         lat_rs = 1'b0;
  int         acc_cyc = 0;
  logic [7:0] exp_data = 8'd0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs for this cycle, then check outputs against the model.
  task automatic step(input logic rv, input logic rs, input logic busy,
                      input logic [7:0] d, input logic rst);
    int  k;
    bit  e_en, e_own, e_rv, e_rdy;
    @(posedge clk);
    cyc++;
    #1;
    req_valid   = rv;
    req_rs      = rs;
    bus_busy    = busy;
    lcd_data_in = d;
    reset       = rst;
    #1;
    if (model_on) begin
      k     = in_txn ? (cyc - acc_cyc) : 0;
      e_en  = in_txn && (k >= S + 1) && (k <= S + E);
      e_own = in_txn && (k >= 1) && (k <= S + E + H);
      e_rv  = in_txn && (k == S + E + 1);
      e_rdy = !in_txn && !busy && !rst;
      chk("lcd_en", lcd_en, e_en);
      chk("bus_own", bus_own, e_own);
      chk("lcd_rw", lcd_rw, e_own);
      chk("resp_valid", resp_valid, e_rv);
      chk("req_ready", req_ready, e_rdy);
      chk("resp_data", resp_data, exp_data);
      chk("resp_timeout", resp_timeout, 1'b0);
      if (e_own) chk("lcd_rs", lcd_rs, lat_rs);
      if (rst) begin
        in_txn   = 1'b0;
        exp_data = 8'd0;
      end else if (in_txn) begin
        if (k == S + E) exp_data = d;
        if (k == S + E + H + R) in_txn = 1'b0;
      end else if (rv && e_rdy) begin
        in_txn  = 1'b1;
        acc_cyc = cyc;
        lat_rs  = rs;
      end
    end
  endtask

`ifdef LCD_BUSY_POLL_EN
  // RS=1 request with busy polling; data returned per EN pulse index.
  task automatic poll_run(input int n_busy, input bit stuck);
    int         cmd_p = 0, dat_p = 0, resp_n = 0, own_gap = 0, pulses = 0;
    bit         prev_en = 1'b0, done = 1'b0, rtmo = 1'b0;
    logic [7:0] d = 8'd0, last_busy = 8'd0, rdata = 8'd0;
    model_on = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1; req_rs = 1'b1; bus_busy = 1'b0; reset = 1'b0; lcd_data_in = 8'd0;
    for (int i = 0; i < 800 && !done; i++) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      if (lcd_en && !prev_en) begin
        pulses++;
        if (lcd_rs) dat_p++;
        else cmd_p++;
        if (stuck || pulses <= n_busy) d = 8'h80 | 8'($urandom_range(127));
        else if (pulses == n_busy + 1) d = 8'($urandom_range(127));
        else d = 8'h5A;
        if (!lcd_rs) last_busy = d;
      end
      prev_en = lcd_en;
      lcd_data_in = d;
      if (pulses > 0 && resp_n == 0 && !bus_own) own_gap++;
      if (resp_valid) begin
        resp_n++;
        rdata = resp_data;
        rtmo  = resp_timeout;
      end
      #1;
      if (resp_n > 0 && req_ready) done = 1'b1;
    end
    chk("poll_done", done, 1'b1);
    chk("poll_resp_n", resp_n, 1);
    chk("poll_own_gap", own_gap, 0);
    if (stuck) begin
      chk("poll_cmd_pulses", cmd_p, PLIM);
      chk("poll_data_pulses", dat_p, 0);
      chk("poll_data", rdata, last_busy);
      chk("poll_timeout", rtmo, 1'b1);
    end else begin
      chk("poll_cmd_pulses", cmd_p, n_busy + 1);
      chk("poll_data_pulses", dat_p, 1);
      chk("poll_data", rdata, 8'h5A);
      chk("poll_timeout", rtmo, 1'b0);
    end
  endtask
`endif

  initial begin
    #10ms;
    $display("FAIL watchdog time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int  en_len, rv_off, rdy_off;
    bit  rs_ok;
`ifdef LCD_BUSY_POLL_EN
    rs_ok = 1'b0;
`else
    rs_ok = 1'b1;
`endif
    // Reset: first cycle unchecked (pre-reset state unknown), then check reset values.
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    model_on = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);

    // Single status read of 8'h85 with explicit timing measurements.
    step(1'b1, 1'b0, 1'b0, 8'h85, 1'b0);
    en_len = 0; rv_off = -1; rdy_off = -1;
    for (int i = 1; i <= 60; i++) begin
      step(1'b0, 1'b0, 1'b0, 8'h85, 1'b0);
      if (lcd_en) en_len++;
      if (resp_valid && rv_off < 0) rv_off = i;
      if (req_ready && rdy_off < 0) rdy_off = i;
    end
    chk("en_len", en_len, E);
    chk("resp_cycle", rv_off, S + E + 1);
    chk("ready_cycle", rdy_off, S + E + H + R + 1);
    chk("resp_85", resp_data, 8'h85);

    // Back-to-back requests held valid (data read of 8'h41).
    for (int i = 0; i < 110; i++) step(1'b1, rs_ok, 1'b0, 8'h41, 1'b0);
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b0, 8'h41, 1'b0);

    // Writer owns the bus for 10 cycles while a request waits.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1, 8'h33, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h33, 1'b0);
    for (int i = 0; i < 55; i++) step(1'b0, 1'b0, 1'b0, 8'h33, 1'b0);

    // Reset in offset 15 (mid EN_HIGH) aborts the transaction.
    step(1'b1, 1'b0, 1'b0, 8'h77, 1'b0);
    for (int i = 1; i < 15; i++) step(1'b0, 1'b0, 1'b0, 8'h77, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h77, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, 8'h77, 1'b0);

    // Randomized traffic, including rare resets and writer contention.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(1)),
           rs_ok ? 1'($urandom_range(1)) : 1'b0,
           ($urandom_range(9) < 2),
           8'($urandom_range(255)),
           ($urandom_range(999) < 3));
    end
    for (int i = 0; i < 60; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

`ifdef LCD_BUSY_POLL_EN
    poll_run(3, 1'b0);
    poll_run(0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
